// File: rtl/mdu_iter_pkg.sv
// Shared opcode and FSM state definitions for the iterative multiply/divide unit.
package mdu_iter_pkg;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MFHI  = 4'd4,
    MDU_MFLO  = 4'd5,
    MDU_MTHI  = 4'd6,
    MDU_MTLO  = 4'd7,
    MDU_MADD  = 4'd8,
    MDU_MADDU = 4'd9,
    MDU_MSUB  = 4'd10,
    MDU_MSUBU = 4'd11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_S_IDLE,
    MDU_S_MUL,
    MDU_S_DIV,
    MDU_S_FIX
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

  function automatic logic is_add_op(input logic [3:0] op);
    return op inside {MDU_MADD, MDU_MADDU};
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    return op inside {MDU_MSUB, MDU_MSUBU};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned iterative restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted;
  logic             ge;

  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    done_d  = done_q;
    // The partial remainder never reaches 2*divisor, so a WIDTH-bit subtract is exact.
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs_q};
    if (abort) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(WIDTH);
      done_d = 1'b0;
    end else if (cnt_q != '0) begin
      rem_d  = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], ge};
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/mdu_iter.sv
// EX-stage multiply/divide unit: fixed-latency multiply/accumulate, iterative divide, HI/LO.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned OP_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Cancel,
  input  logic            Start,
  input  logic [OP_W-1:0] Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] DO,
  output logic            Busy
);

  localparam int unsigned MAX_CNT = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [3:0]         op_q, op_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, bzero_q, bzero_d;

  logic [3:0]         op4;
  logic               sgn, div_start, div_done;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, hilo;
  logic [WIDTH-1:0]   div_a, div_b, div_quo, div_rem;

  assign op4   = 4'(Op);
  assign sgn   = is_signed_op(op4);
  assign ext_a = sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign ext_b = sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign prod  = ext_a * ext_b;
  assign div_a = (sgn && A[WIDTH-1]) ? -A : A;
  assign div_b = (sgn && B[WIDTH-1]) ? -B : B;
  assign hilo  = {hi_q, lo_q};
  assign Busy  = (state_q != MDU_S_IDLE);

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .abort     (Cancel),
    .start     (div_start),
    .dividend  (div_a),
    .divisor   (div_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    prod_d    = prod_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    bzero_d   = bzero_q;
    div_start = 1'b0;
    if (Cancel) begin
      state_d = MDU_S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        MDU_S_IDLE: begin
          if (Start) begin
            if (is_mul_op(op4)) begin
              state_d = MDU_S_MUL;
              cnt_d   = '0;
              op_d    = op4;
              prod_d  = prod;
            end else if (is_div_op(op4)) begin
              state_d   = MDU_S_DIV;
              cnt_d     = '0;
              div_start = 1'b1;
              a_d       = A;
              qneg_d    = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
              rneg_d    = sgn && A[WIDTH-1];
              bzero_d   = (B == '0);
            end
          end else if (op4 == MDU_MTHI) begin
            hi_d = A;
          end else if (op4 == MDU_MTLO) begin
            lo_d = A;
          end
        end
        MDU_S_MUL: begin
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            state_d = MDU_S_IDLE;
            cnt_d   = '0;
            if (is_add_op(op_q))      {hi_d, lo_d} = hilo + prod_q;
            else if (is_sub_op(op_q)) {hi_d, lo_d} = hilo - prod_q;
            else                      {hi_d, lo_d} = prod_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MDU_S_DIV: begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = MDU_S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MDU_S_FIX: begin
          if (div_done) begin
            state_d = MDU_S_IDLE;
            // -2^(W-1)/-1 yields quotient 2^(W-1) whose negation wraps back to -2^(W-1), rem 0.
            if (bzero_q) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              lo_d = qneg_q ? -div_quo : div_quo;
              hi_d = rneg_q ? -div_rem : div_rem;
            end
          end
        end
        default: state_d = MDU_S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      prod_q  <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
    end
  end

  always_comb begin
    DO = '0;
    if (op4 == MDU_MFHI)      DO = hi_q;
    else if (op4 == MDU_MFLO) DO = lo_q;
  end

endmodule
